// File: rtl/dctq_pkg.sv
// Shared helpers for the DCTQ adder tree: width/latency arithmetic and default split point.
package dctq_pkg;

  localparam int DCTQ_SPLIT_DEF = 7;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Two register stages per tree level.
  function automatic int adder_lat(input int n);
    return 2 * clog2(n);
  endfunction

endpackage

// File: rtl/dctq_split_add2.sv
// Two-stage pair adder: LSB chunk in stage A, MSB chunk plus registered carry in stage B.
module dctq_split_add2 #(
  parameter int W     = 14,
  parameter int SPLIT = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce_i,
  input  logic         out_en_i,
  input  logic         mode_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   sum_o
);

  localparam int MW = W - SPLIT;

  logic [SPLIT:0]   lsb_q, lsb_d;
  logic [MW-1:0]    msb_a_q, msb_b_q;
  logic [SPLIT-1:0] lsb_b_q;
  logic [MW:0]      msb_q, msb_d;

  always_comb begin
    lsb_d = {1'b0, a_i[SPLIT-1:0]} + {1'b0, b_i[SPLIT-1:0]};
  end

  // mode_i belongs to the operands currently held in stage A.
  always_comb begin
    msb_d = {mode_i & msb_a_q[MW-1], msb_a_q}
          + {mode_i & msb_b_q[MW-1], msb_b_q}
          + {{MW{1'b0}}, lsb_q[SPLIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsb_q   <= '0;
      msb_a_q <= '0;
      msb_b_q <= '0;
      msb_q   <= '0;
      lsb_b_q <= '0;
    end else begin
      if (ce_i) begin
        lsb_q   <= lsb_d;
        msb_a_q <= a_i[W-1:SPLIT];
        msb_b_q <= b_i[W-1:SPLIT];
      end
      if (ce_i && out_en_i) begin
        msb_q   <= msb_d;
        lsb_b_q <= lsb_q[SPLIT-1:0];
      end
    end
  end

  assign sum_o = {msb_q, lsb_b_q};

endmodule

// File: rtl/dctq_adder_tree_p.sv
// Pipelined N_IN-operand adder tree with valid/mode tracking, clock-enable stall and held output.
module dctq_adder_tree_p
  import dctq_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int IN_W  = 14,
  parameter int SPLIT = DCTQ_SPLIT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ce,
  input  logic                           in_valid,
  input  logic                           in_signed,
  input  logic [N_IN*IN_W-1:0]           din,
  output logic                           out_valid,
  output logic [IN_W+clog2(N_IN)-1:0]    sum,
  output logic                           out_signed
);

  localparam int LEVELS = clog2(N_IN);
  localparam int LAT    = adder_lat(N_IN);

  if (N_IN < 2 || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n
    $error("dctq_adder_tree_p: N_IN must be a power of 2 and >= 2");
  end
  if (SPLIT < 1 || SPLIT >= IN_W) begin : g_bad_split
    $error("dctq_adder_tree_p: SPLIT must satisfy 1 <= SPLIT < IN_W");
  end

  // vld_q[k] / mode_q[k] describe the data held in pipeline register k.
  logic [LAT-1:0] vld_q;
  logic [LAT-2:0] mode_q;
  logic           out_signed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      mode_q       <= '0;
      out_signed_q <= 1'b0;
    end else if (ce) begin
      vld_q[0]  <= in_valid;
      mode_q[0] <= in_signed;
      for (int k = 1; k < LAT; k++) vld_q[k] <= vld_q[k-1];
      for (int k = 1; k < LAT - 1; k++) mode_q[k] <= mode_q[k-1];
      if (vld_q[LAT-2]) out_signed_q <= mode_q[LAT-2];
    end
  end

  for (genvar gi = 1; gi <= LEVELS; gi++) begin : g_lvl
    localparam int W  = IN_W + gi - 1;
    localparam int NP = N_IN >> gi;

    logic [2*NP*W-1:0]    src;
    logic [NP*(W+1)-1:0]  res;

    if (gi == 1) begin : g_src_in
      assign src = din;
    end else begin : g_src_lvl
      assign src = g_lvl[gi-1].res;
    end

    // The last level's stage B doubles as the held output register.
    for (genvar gj = 0; gj < NP; gj++) begin : g_pair
      dctq_split_add2 #(
        .W     (W),
        .SPLIT (SPLIT)
      ) u_add (
        .clk      (clk),
        .rst      (rst),
        .ce_i     (ce),
        .out_en_i ((gi == LEVELS) ? vld_q[LAT-2] : 1'b1),
        .mode_i   (mode_q[2*(gi-1)]),
        .a_i      (src[2*gj*W +: W]),
        .b_i      (src[(2*gj+1)*W +: W]),
        .sum_o    (res[gj*(W+1) +: W+1])
      );
    end
  end

  assign sum        = g_lvl[LEVELS].res;
  assign out_valid  = vld_q[LAT-1];
  assign out_signed = out_signed_q;

endmodule
